// File: rtl/codeconv_controller.sv
// Sequencing FSM for the code-converter datapath: load, convert, store.
// Adds a done-wait timeout and a wrapping count of good conversions.
module codeconv_controller #(
  parameter int TIMEOUT = 16,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    sel,
  output logic          ldA,
  output logic          ldR,
  output logic          G,
  output logic          B,
  output logic          E,
  input  logic          done_gray,
  input  logic          done_bcd,
  input  logic          done_excess3,
  output logic [CW-1:0] conv_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CONV,
    S_STORE,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic [7:0]      tmo_q, tmo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            match_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mode_q  <= 2'b00;
      tmo_q   <= 8'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  // Only the converter picked by the latched mode is listened to.
  always_comb begin
    match_done = 1'b0;
    unique case (mode_q)
      2'b00:   match_done = done_gray;
      2'b01:   match_done = done_bcd;
      2'b10:   match_done = done_excess3;
      default: match_done = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (mode == 2'b11) begin
            state_d = S_ERR;
          end else begin
            mode_d  = mode;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        tmo_d   = 8'd0;
        state_d = S_CONV;
      end
      S_CONV: begin
        if (match_done) begin
          state_d = S_STORE;
        end else if (tmo_q == 8'(TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_STORE: begin
        state_d = S_DONE;
        cnt_d   = cnt_q + CW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore decode: every output depends only on registered state.
  always_comb begin
    G = 1'b0;
    B = 1'b0;
    E = 1'b0;
    if (state_q == S_CONV) begin
      unique case (1'b1)
        (mode_q == 2'b00): G = 1'b1;
        (mode_q == 2'b01): B = 1'b1;
        (mode_q == 2'b10): E = 1'b1;
        default: ;
      endcase
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERR);
  assign ldA        = (state_q == S_LOAD);
  assign ldR        = (state_q == S_STORE);
  assign sel        = mode_q;
  assign conv_count = cnt_q;

endmodule

// File: tb/tb_codeconv_controller.sv
// Scoreboard bench for codeconv_controller, default and CW=2 instances.
module tb_codeconv_controller;

  logic clk = 1'b0;
  logic rst, start, fast;
  logic [1:0] mode;
  logic dg_r, db_r, de_r;
  logic done_gray, done_bcd, done_excess3;

  logic busy, done, err, ldA, ldR, G, B, E;
  logic [1:0] sel;
  logic [7:0] conv_count;
  logic busy2, done2, err2, ldA2, ldR2, G2, B2, E2;
  logic [1:0] sel2;
  logic [1:0] cnt2;

  typedef struct packed {
    logic [9:0] v;
    logic [7:0] c;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int tests, fails;
  logic [7:0] ecnt;

  always #5 clk = ~clk;

  assign done_gray    = fast ? G : dg_r;
  assign done_bcd     = fast ? B : db_r;
  assign done_excess3 = fast ? E : de_r;

  codeconv_controller #(.TIMEOUT(16), .CW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .busy(busy), .done(done), .err(err), .sel(sel),
    .ldA(ldA), .ldR(ldR), .G(G), .B(B), .E(E),
    .done_gray(done_gray), .done_bcd(done_bcd),
    .done_excess3(done_excess3), .conv_count(conv_count)
  );

  codeconv_controller #(.TIMEOUT(16), .CW(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .busy(busy2), .done(done2), .err(err2), .sel(sel2),
    .ldA(ldA2), .ldR(ldR2), .G(G2), .B(B2), .E(E2),
    .done_gray(done_gray), .done_bcd(done_bcd),
    .done_excess3(done_excess3), .conv_count(cnt2)
  );

  // ph: 0 IDLE, 1 LOAD, 2 CONV, 3 STORE, 4 DONE, 5 ERR
  function automatic logic [9:0] ev(input int ph, input logic [1:0] s);
    logic [9:0] r;
    r    = '0;
    r[9] = (ph != 0);
    r[8] = (ph == 4);
    r[7] = (ph == 5);
    r[6:5] = s;
    r[4] = (ph == 1);
    r[3] = (ph == 3);
    r[2] = (ph == 2) && (s == 2'd0);
    r[1] = (ph == 2) && (s == 2'd1);
    r[0] = (ph == 2) && (s == 2'd2);
    return r;
  endfunction

  function automatic logic [9:0] obs();
    return {busy, done, err, sel, ldA, ldR, G, B, E};
  endfunction

  function automatic logic [9:0] obs2();
    return {busy2, done2, err2, sel2, ldA2, ldR2, G2, B2, E2};
  endfunction

  function automatic exp_t mk(input int ph, input logic [1:0] s);
    exp_t x;
    x.v = ev(ph, s);
    x.c = ecnt;
    return x;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({obs(), obs2()} !== 20'd0) begin
      fails++;
      $display("FAIL reset_out got %b %b exp 0", obs(), obs2());
    end
    tests++;
    if ({conv_count, cnt2} !== 10'd0) begin
      fails++;
      $display("FAIL reset_cnt got %0d %0d exp 0", conv_count, cnt2);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({obs(), obs2()} !== 20'd0) begin
      fails++;
      $display("FAIL reset_idle got %b %b exp 0", obs(), obs2());
    end
  endtask

  task automatic test_gray();
    q.push_back(mk(1, 2'd0));
    q.push_back(mk(2, 2'd0));
    q.push_back(mk(2, 2'd0));
    q.push_back(mk(3, 2'd0));
    ecnt++;
    q.push_back(mk(4, 2'd0));
    q.push_back(mk(0, 2'd0));
    mode  = 2'd0;
    start = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      dg_r  = (i == 3);
      e = q.pop_front();
      tests++;
      if ({obs(), obs2()} !== {e.v, e.v}) begin
        fails++;
        $display("FAIL gray_c%0d got %b %b exp %b", i, obs(), obs2(), e.v);
      end
      tests++;
      if ({conv_count, cnt2} !== {e.c, e.c[1:0]}) begin
        fails++;
        $display("FAIL gray_cnt_c%0d got %0d %0d exp %0d", i, conv_count, cnt2, e.c);
      end
    end
  endtask

  task automatic test_bcd();
    q.push_back(mk(1, 2'd1));
    for (int k = 0; k < 3; k++) q.push_back(mk(2, 2'd1));
    q.push_back(mk(3, 2'd1));
    ecnt++;
    q.push_back(mk(4, 2'd1));
    q.push_back(mk(0, 2'd1));
    mode  = 2'd1;
    start = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      dg_r  = (i == 2) || (i == 4);
      de_r  = (i == 3);
      db_r  = (i == 4);
      e = q.pop_front();
      tests++;
      if ({obs(), obs2()} !== {e.v, e.v}) begin
        fails++;
        $display("FAIL bcd_c%0d got %b %b exp %b", i, obs(), obs2(), e.v);
      end
      tests++;
      if ({conv_count, cnt2} !== {e.c, e.c[1:0]}) begin
        fails++;
        $display("FAIL bcd_cnt_c%0d got %0d %0d exp %0d", i, conv_count, cnt2, e.c);
      end
    end
  endtask

  task automatic test_timeout();
    q.push_back(mk(1, 2'd2));
    for (int k = 0; k < 16; k++) q.push_back(mk(2, 2'd2));
    q.push_back(mk(5, 2'd2));
    q.push_back(mk(0, 2'd2));
    mode  = 2'd2;
    start = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      dg_r  = (i < 19);
      db_r  = (i < 19);
      de_r  = 1'b0;
      e = q.pop_front();
      tests++;
      if ({obs(), obs2()} !== {e.v, e.v}) begin
        fails++;
        $display("FAIL timeout_c%0d got %b %b exp %b", i, obs(), obs2(), e.v);
      end
      tests++;
      if ({conv_count, cnt2} !== {e.c, e.c[1:0]}) begin
        fails++;
        $display("FAIL timeout_cnt_c%0d got %0d %0d exp %0d", i, conv_count, cnt2, e.c);
      end
    end
  endtask

  task automatic test_illegal();
    q.push_back(mk(5, 2'd2));
    q.push_back(mk(0, 2'd2));
    mode  = 2'd3;
    start = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      e = q.pop_front();
      tests++;
      if ({obs(), obs2()} !== {e.v, e.v}) begin
        fails++;
        $display("FAIL illegal_c%0d got %b %b exp %b", i, obs(), obs2(), e.v);
      end
      tests++;
      if ({conv_count, cnt2} !== {e.c, e.c[1:0]}) begin
        fails++;
        $display("FAIL illegal_cnt_c%0d got %0d %0d exp %0d", i, conv_count, cnt2, e.c);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] modes [4];
    int k, p;
    int phs [5];
    modes[0] = 2'd0; modes[1] = 2'd1;
    modes[2] = 2'd2; modes[3] = 2'd0;
    phs[0] = 1; phs[1] = 2; phs[2] = 3; phs[3] = 4; phs[4] = 0;
    for (int i = 1; i <= 20; i++) begin
      k = (i - 1) / 5;
      p = (i - 1) % 5;
      if (p == 3) ecnt++;
      q.push_back(mk(phs[p], modes[k]));
    end
    q.push_back(mk(0, modes[3]));
    fast  = 1'b1;
    mode  = modes[0];
    start = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      @(posedge clk); #1;
      k = (i - 1) / 5;
      if ((i % 5 == 2) && (k < 3)) mode = modes[k+1];
      if (i == 20) start = 1'b0;
      e = q.pop_front();
      tests++;
      if ({obs(), obs2()} !== {e.v, e.v}) begin
        fails++;
        $display("FAIL b2b_c%0d got %b %b exp %b", i, obs(), obs2(), e.v);
      end
      tests++;
      if ({conv_count, cnt2} !== {e.c, e.c[1:0]}) begin
        fails++;
        $display("FAIL b2b_cnt_c%0d got %0d %0d exp %0d", i, conv_count, cnt2, e.c);
      end
    end
    fast = 1'b0;
  endtask

  task automatic test_reset_mid();
    q.push_back(mk(1, 2'd1));
    q.push_back(mk(2, 2'd1));
    q.push_back(mk(2, 2'd1));
    mode  = 2'd1;
    start = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      e = q.pop_front();
      tests++;
      if ({obs(), obs2()} !== {e.v, e.v}) begin
        fails++;
        $display("FAIL rstmid_c%0d got %b %b exp %b", i, obs(), obs2(), e.v);
      end
    end
    #2 rst = 1'b0;
    ecnt = 8'd0;
    #1;
    tests++;
    if ({obs(), obs2(), conv_count, cnt2} !== 30'd0) begin
      fails++;
      $display("FAIL rstmid_async got %b %b %0d %0d exp 0", obs(), obs2(), conv_count, cnt2);
    end
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) q.push_back(mk(0, 2'd0));
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      e = q.pop_front();
      tests++;
      if ({obs(), obs2()} !== {e.v, e.v}) begin
        fails++;
        $display("FAIL rstmid_idle_c%0d got %b %b exp %b", i, obs(), obs2(), e.v);
      end
      tests++;
      if ({conv_count, cnt2} !== {e.c, e.c[1:0]}) begin
        fails++;
        $display("FAIL rstmid_cnt_c%0d got %0d %0d exp %0d", i, conv_count, cnt2, e.c);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    ecnt  = 8'd0;
    rst   = 1'b1;
    start = 1'b0;
    mode  = 2'd0;
    fast  = 1'b0;
    dg_r  = 1'b0;
    db_r  = 1'b0;
    de_r  = 1'b0;
    test_reset();
    test_gray();
    test_bcd();
    test_timeout();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_gray();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
